// File: rtl/obi_dual_hart_mem_responder_if.sv
// OBI payload types and the multi-port request/response bundle between the
// harts (master) and the scratch-memory responder (slave).
package obi_dual_hart_mem_responder_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

interface obi_dual_hart_mem_responder_if
    import obi_dual_hart_mem_responder_pkg::*;
#(
    parameter int unsigned NHARTS = 2
);
    obi_req_t  req_i  [NHARTS];
    obi_resp_t resp_o [NHARTS];

    modport master (output req_i, input  resp_o);
    modport slave  (input  req_i, output resp_o);
endinterface

// File: rtl/obi_dual_hart_mem_responder.sv
// Multi-port OBI responder over one single-port word SRAM: round-robin grant,
// one transaction per cycle, responses returned in grant order after RD_LATENCY.
module obi_dual_hart_mem_responder
    import obi_dual_hart_mem_responder_pkg::*;
#(
    parameter int unsigned NHARTS     = 2,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'hF001_0000,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [31:0] ERR_DATA   = 32'hBADC_AB1E
) (
    input logic                          clk_i,
    input logic                          rst_i,
    obi_dual_hart_mem_responder_if.slave bus
);

    localparam int unsigned AW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PW   = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam logic [31:0] SPAN = 32'(4 * NUM_WORDS);
    localparam int unsigned LAST = RD_LATENCY - 1;

    logic [PW-1:0] rr_q;
    logic [PW-1:0] rr_d;
    logic          rst_seen_q;

    logic          gnt_en_c;
    logic          found_c;
    logic [PW-1:0] win_c;
    obi_req_t      sel_c;

    logic [31:0]   off_c;
    logic          in_range_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   rd_c;

    logic [31:0]   mem_q [NUM_WORDS];

    logic          pv_q    [RD_LATENCY];
    logic [PW-1:0] pid_q   [RD_LATENCY];
    logic [31:0]   pdata_q [RD_LATENCY];

    logic          pv_d;
    logic [PW-1:0] pid_d;
    logic [31:0]   pdata_d;

    logic          unused_bits_c;

    // Round-robin search from rr_q upward; suppressed during reset and the cycle after
    always_comb begin
        found_c  = 1'b0;
        win_c    = '0;
        sel_c    = '0;
        gnt_en_c = !rst_i && !rst_seen_q;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            for (int unsigned p = 0; p < NHARTS; p++) begin
                if (gnt_en_c && !found_c && bus.req_i[p].req &&
                    ((32'(rr_q) + i == p) || (32'(rr_q) + i == p + NHARTS))) begin
                    found_c = 1'b1;
                    win_c   = PW'(p);
                    sel_c   = bus.req_i[p];
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (found_c) begin
            rr_d = (32'(win_c) == NHARTS - 1) ? '0 : win_c + 1'b1;
        end
    end

    // Unsigned offset also rejects addresses below BASE_ADDR via wrap-around
    assign off_c      = sel_c.addr - BASE_ADDR;
    assign in_range_c = (off_c < SPAN);
    assign idx_c      = off_c[AW+1:2];

    always_comb begin
        rd_c = '0;
        if (found_c && !sel_c.we) begin
            rd_c = in_range_c ? mem_q[idx_c] : ERR_DATA;
        end
    end

    assign pv_d    = found_c;
    assign pid_d   = win_c;
    assign pdata_d = rd_c;

    // SRAM byte-masked write at the grant edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (found_c && sel_c.we && in_range_c) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (sel_c.be[b]) begin
                    mem_q[idx_c][8*b +: 8] <= sel_c.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            rst_seen_q <= 1'b1;
            for (int unsigned s = 0; s < RD_LATENCY; s++) begin
                pv_q[s]    <= 1'b0;
                pid_q[s]   <= '0;
                pdata_q[s] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            rst_seen_q <= 1'b0;
            pv_q[0]    <= pv_d;
            pid_q[0]   <= pid_d;
            pdata_q[0] <= pdata_d;
            for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                pv_q[s]    <= pv_q[s-1];
                pid_q[s]   <= pid_q[s-1];
                pdata_q[s] <= pdata_q[s-1];
            end
        end
    end

    // Response fan-out; rvalid masked while rst_i is high so in-flight data never escapes
    always_comb begin
        for (int unsigned p = 0; p < NHARTS; p++) begin
            bus.resp_o[p]        = '0;
            bus.resp_o[p].gnt    = found_c && (win_c == PW'(p));
            bus.resp_o[p].rvalid = pv_q[LAST] && !rst_i && (pid_q[LAST] == PW'(p));
            if (pv_q[LAST] && !rst_i && (pid_q[LAST] == PW'(p))) begin
                bus.resp_o[p].rdata = pdata_q[LAST];
            end
        end
    end

    assign unused_bits_c = ^{sel_c.req, off_c[1:0], off_c[31:AW+2]};

endmodule

// File: tb/tb_obi_dual_hart_mem_responder.sv
// Bench for the OBI scratch-memory responder: three instances (latency 1, 3, 2)
// checked against a reference memory model and an in-order response scoreboard.
module tb_obi_dual_hart_mem_responder;
    import obi_dual_hart_mem_responder_pkg::*;

    localparam logic [31:0] B   = 32'hF001_0000;
    localparam logic [31:0] ERR = 32'hBADC_AB1E;
    localparam int          NW  = 1024;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   lat [3] = '{1, 3, 2};

    exp_t        sb  [3][$];
    logic [31:0] mdl [3][NW];

    obi_dual_hart_mem_responder_if #(.NHARTS(2)) if_a ();
    obi_dual_hart_mem_responder_if #(.NHARTS(2)) if_b ();
    obi_dual_hart_mem_responder_if #(.NHARTS(2)) if_c ();

    obi_dual_hart_mem_responder #(.NHARTS(2), .RD_LATENCY(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bus(if_a.slave));
    obi_dual_hart_mem_responder #(.NHARTS(2), .RD_LATENCY(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bus(if_b.slave));
    obi_dual_hart_mem_responder #(.NHARTS(2), .RD_LATENCY(2)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .bus(if_c.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obi_resp_t resp_of(input int d, input int p);
        case (d)
            0:       return if_a.resp_o[p];
            1:       return if_b.resp_o[p];
            default: return if_c.resp_o[p];
        endcase
    endfunction

    function automatic logic [1:0] gnts(input int d);
        obi_resp_t r0, r1;
        r0 = resp_of(d, 0);
        r1 = resp_of(d, 1);
        return {r1.gnt, r0.gnt};
    endfunction

    task automatic drv(input int d, input int p, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        obi_req_t r;
        r = '{req: v, addr: a, we: we, be: be, wdata: wd};
        case (d)
            0:       if_a.req_i[p] = r;
            1:       if_b.req_i[p] = r;
            default: if_c.req_i[p] = r;
        endcase
    endtask

    task automatic clr_all();
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 2; p++)
                drv(d, p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Reference memory update and expected response for a granted transaction
    task automatic expect_txn(input int d, input int p, input logic we,
                              input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] off;
        logic [31:0] data;
        int          idx;
        bit          inr;
        off  = a - B;
        inr  = (off < 32'(4 * NW));
        idx  = int'(off[11:2]);
        data = 32'h0;
        if (we) begin
            if (inr)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            data = inr ? mdl[d][idx] : ERR;
        end
        sb[d].push_back('{due: cyc + lat[d], port: p, data: data});
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sb[d].size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb[d].size() > 0) begin
            failures++;
            $display("FAIL drain dut%0d: %0d responses outstanding, want 0", d, sb[d].size());
        end
    endtask

    // Response scoreboard: every port of every instance checked each cycle
    always @(negedge clk) begin : mon
        obi_resp_t   r;
        logic        ev;
        logic [31:0] ed;
        for (int d = 0; d < 3; d++) begin
            if (rst) sb[d].delete();
            for (int p = 0; p < 2; p++) begin
                r  = resp_of(d, p);
                ev = 1'b0;
                ed = 32'h0;
                if (sb[d].size() > 0 && sb[d][0].due == cyc && sb[d][0].port == p) begin
                    ev = 1'b1;
                    ed = sb[d][0].data;
                end
                checks++;
                if (r.rvalid !== ev || r.rdata !== ed) begin
                    failures++;
                    $display("FAIL resp dut%0d port%0d cyc%0d: rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                             d, p, cyc, r.rvalid, r.rdata, ev, ed);
                end
            end
            if (sb[d].size() > 0 && sb[d][0].due <= cyc) void'(sb[d].pop_front());
        end
    end

    task automatic test_reset();
        logic [1:0] g;
        drv(0, 0, 1'b1, 1'b0, B, 32'h0, 4'hF);
        drv(0, 1, 1'b1, 1'b0, B + 32'h4, 32'h0, 4'hF);
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                g = gnts(d);
                checks++;
                if (g !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_gnt dut%0d: gnt=%b, want 00", d, g);
                end
            end
        end
        cyc_start();
        rst = 1'b0;
        @(negedge clk);
        g = gnts(0);
        checks++;
        if (g !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_gnt: gnt=%b, want 00", g);
        end
        cyc_start();
        clr_all();
    endtask

    task automatic test_basic_rw();
        logic        v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] wd [4] = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        logic [1:0]  eg [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        logic [1:0]  g;
        for (int i = 0; i < 4; i++) begin
            cyc_start();
            drv(0, 0, v[i], we[i], B + 32'h10, wd[i], 4'hF);
            @(negedge clk);
            g = gnts(0);
            checks++;
            if (g !== eg[i]) begin
                failures++;
                $display("FAIL basic_gnt step%0d: gnt=%b, want %b", i, g, eg[i]);
            end
            if (v[i]) expect_txn(0, 0, we[i], B + 32'h10, wd[i], 4'hF);
        end
        cyc_start();
        clr_all();
        drain(0);
    endtask

    task automatic test_byte_en();
        logic        we [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] wd [3] = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0};
        logic [3:0]  be [3] = '{4'b1111, 4'b0101, 4'b0000};
        logic [1:0]  g;
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            drv(0, 1, 1'b1, we[i], B + 32'h20, wd[i], be[i]);
            @(negedge clk);
            g = gnts(0);
            checks++;
            if (g !== 2'b10) begin
                failures++;
                $display("FAIL byte_en_gnt step%0d: gnt=%b, want 10", i, g);
            end
            expect_txn(0, 1, we[i], B + 32'h20, wd[i], be[i]);
        end
        cyc_start();
        clr_all();
        drain(0);
    endtask

    task automatic test_out_of_range();
        logic        we [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] a  [7] = '{B, B + 32'h1000, B + 32'h1000, B,
                                B + 32'hFFC, B + 32'hFFC, B - 32'h4};
        logic [31:0] wd [7] = '{32'h0, 32'h0, 32'h1234_5678, 32'h0,
                                32'hCAFE_F00D, 32'h0, 32'h0};
        logic [1:0]  g;
        for (int i = 0; i < 7; i++) begin
            cyc_start();
            drv(0, 0, 1'b1, we[i], a[i], wd[i], 4'hF);
            @(negedge clk);
            g = gnts(0);
            checks++;
            if (g !== 2'b01) begin
                failures++;
                $display("FAIL oor_gnt step%0d: gnt=%b, want 01", i, g);
            end
            expect_txn(0, 0, we[i], a[i], wd[i], 4'hF);
        end
        cyc_start();
        clr_all();
        drain(0);
    endtask

    task automatic test_contention();
        logic [31:0] a  [2] = '{B + 32'h100, B + 32'h104};
        logic [31:0] wd [2] = '{32'hA0A0_0001, 32'hB0B0_0002};
        logic [1:0]  g;
        logic [1:0]  eg;
        for (int i = 0; i < 2; i++) begin
            cyc_start();
            drv(0, 0, 1'b1, 1'b1, a[i], wd[i], 4'hF);
            @(negedge clk);
            g = gnts(0);
            checks++;
            if (g !== 2'b01) begin
                failures++;
                $display("FAIL contention_preload_gnt step%0d: gnt=%b, want 01", i, g);
            end
            expect_txn(0, 0, 1'b1, a[i], wd[i], 4'hF);
        end
        cyc_start();
        clr_all();
        drain(0);
        cyc_start();
        rst = 1'b1;
        cyc_start();
        rst = 1'b0;
        drv(0, 0, 1'b1, 1'b0, a[0], 32'h0, 4'hF);
        drv(0, 1, 1'b1, 1'b0, a[1], 32'h0, 4'hF);
        @(negedge clk);
        g = gnts(0);
        checks++;
        if (g !== 2'b00) begin
            failures++;
            $display("FAIL contention_post_reset_gnt: gnt=%b, want 00", g);
        end
        for (int i = 0; i < 6; i++) begin
            cyc_start();
            @(negedge clk);
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            g  = gnts(0);
            checks++;
            if (g !== eg) begin
                failures++;
                $display("FAIL contention_gnt step%0d: gnt=%b, want %b", i, g, eg);
            end
            expect_txn(0, i % 2, 1'b0, a[i % 2], 32'h0, 4'hF);
        end
        cyc_start();
        clr_all();
        drain(0);
    endtask

    task automatic test_latency3();
        logic [1:0] g;
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            drv(1, 0, 1'b1, 1'b1, B + 32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF);
            @(negedge clk);
            g = gnts(1);
            checks++;
            if (g !== 2'b01) begin
                failures++;
                $display("FAIL lat3_wr_gnt step%0d: gnt=%b, want 01", i, g);
            end
            expect_txn(1, 0, 1'b1, B + 32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF);
        end
        cyc_start();
        clr_all();
        drain(1);
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            drv(1, 1, 1'b1, 1'b0, B + 32'(4 * i), 32'h0, 4'hF);
            @(negedge clk);
            g = gnts(1);
            checks++;
            if (g !== 2'b10) begin
                failures++;
                $display("FAIL lat3_rd_gnt step%0d: gnt=%b, want 10", i, g);
            end
            expect_txn(1, 1, 1'b0, B + 32'(4 * i), 32'h0, 4'hF);
        end
        cyc_start();
        clr_all();
        drain(1);
    endtask

    task automatic test_reset_midflight();
        logic [1:0] g;
        cyc_start();
        drv(2, 0, 1'b1, 1'b1, B + 32'h14, 32'h5A5A_0005, 4'hF);
        @(negedge clk);
        g = gnts(2);
        checks++;
        if (g !== 2'b01) begin
            failures++;
            $display("FAIL midflight_preload_gnt: gnt=%b, want 01", g);
        end
        expect_txn(2, 0, 1'b1, B + 32'h14, 32'h5A5A_0005, 4'hF);
        cyc_start();
        clr_all();
        drain(2);
        cyc_start();
        drv(2, 0, 1'b1, 1'b0, B + 32'h14, 32'h0, 4'hF);
        @(negedge clk);
        g = gnts(2);
        checks++;
        if (g !== 2'b01) begin
            failures++;
            $display("FAIL midflight_gnt: gnt=%b, want 01", g);
        end
        expect_txn(2, 0, 1'b0, B + 32'h14, 32'h0, 4'hF);
        cyc_start();
        rst = 1'b1;
        clr_all();
        @(negedge clk);
        g = gnts(2);
        checks++;
        if (g !== 2'b00) begin
            failures++;
            $display("FAIL midflight_in_reset_gnt: gnt=%b, want 00", g);
        end
        cyc_start();
        rst = 1'b0;
        drv(2, 0, 1'b1, 1'b0, B + 32'h14, 32'h0, 4'hF);
        drv(2, 1, 1'b1, 1'b0, B + 32'h14, 32'h0, 4'hF);
        @(negedge clk);
        g = gnts(2);
        checks++;
        if (g !== 2'b00) begin
            failures++;
            $display("FAIL midflight_post_reset_gnt: gnt=%b, want 00", g);
        end
        cyc_start();
        @(negedge clk);
        g = gnts(2);
        checks++;
        if (g !== 2'b01) begin
            failures++;
            $display("FAIL midflight_first_contended_gnt: gnt=%b, want 01", g);
        end
        expect_txn(2, 0, 1'b0, B + 32'h14, 32'h0, 4'hF);
        cyc_start();
        clr_all();
        drain(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clr_all();
        test_reset();
        test_basic_rw();
        test_byte_en();
        test_out_of_range();
        test_contention();
        test_latency3();
        test_reset_midflight();
        cyc_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
